// File: rtl/int_ctrl_if.sv
// Core-side signal bundle for the k6502 exception controller: request and
// mask inputs from the core, selected sequence and vector byte back to it.
interface int_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int IDW   = 3
);
  logic             sync;
  logic             i_flag;
  logic             nmi_n;
  logic [N_IRQ-1:0] irq_n;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_d;
  logic             ack;
  logic             rst;
  logic             nmi;
  logic             irq;
  logic [IDW-1:0]   src_id;
  logic [7:0]       vec_lo;
  logic [N_IRQ-1:0] pending;

  modport master (
    output sync, i_flag, nmi_n, irq_n, mask_we, mask_d, ack,
    input  rst, nmi, irq, src_id, vec_lo, pending
  );

  modport slave (
    input  sync, i_flag, nmi_n, irq_n, mask_we, mask_d, ack,
    output rst, nmi, irq, src_id, vec_lo, pending
  );
endinterface

// File: rtl/int_ctrl.sv
// Reset/NMI/IRQ arbiter for the k6502 core: samples requests on opcode fetch,
// holds one exception until the microcode acks it, and supplies the vector low byte.
module int_ctrl #(
  parameter int         N_IRQ        = 4,
  parameter int         IDW          = 3,
  parameter int         VEC_MODE     = 0,
  parameter logic [7:0] IRQ_VEC_BASE = 8'hE0
) (
  input  logic clk,
  input  logic rst_n,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TAKE_RST = 2'd1,
    TAKE_NMI = 2'd2,
    TAKE_IRQ = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] pending;
  logic             nmi_pend;
  logic             nmi_prev;
  logic [IDW-1:0]   src_id;
  logic             nmi_edge;
  logic             take_irq;

  function automatic logic [IDW-1:0] lowest_set(input logic [N_IRQ-1:0] req);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] irq_vector(input logic [IDW-1:0] id);
    logic [7:0] off;
    off = 8'(id);
    if (VEC_MODE == 1) return IRQ_VEC_BASE + {off[6:0], 1'b0};
    else               return 8'hFE;
  endfunction

  assign nmi_edge = nmi_prev && !bus.nmi_n;
  assign take_irq = (state == IDLE) && bus.sync && !nmi_pend &&
                    (|pending) && !bus.i_flag;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.sync) begin
          if (nmi_pend)                         state_nxt = TAKE_NMI;
          else if ((|pending) && !bus.i_flag)   state_nxt = TAKE_IRQ;
        end
      end
      TAKE_RST, TAKE_NMI, TAKE_IRQ: begin
        if (bus.ack) state_nxt = IDLE;
      end
      default: state_nxt = TAKE_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= TAKE_RST;
      mask     <= '1;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b1;
      pending  <= '0;
      src_id   <= '0;
    end else begin
      state    <= state_nxt;
      nmi_prev <= bus.nmi_n;
      pending  <= ~bus.irq_n & mask;
      if (bus.mask_we) mask <= bus.mask_d;
      // A fresh falling edge outranks the ack that retires the current NMI.
      if (nmi_edge)                           nmi_pend <= 1'b1;
      else if (state == TAKE_NMI && bus.ack)  nmi_pend <= 1'b0;
      if (take_irq) src_id <= lowest_set(pending);
    end
  end

  assign bus.rst     = (state == TAKE_RST);
  assign bus.nmi     = (state == TAKE_NMI);
  assign bus.irq     = (state == TAKE_IRQ);
  assign bus.src_id  = src_id;
  assign bus.pending = pending;

  always_comb begin
    case (state)
      TAKE_RST: bus.vec_lo = 8'hFC;
      TAKE_NMI: bus.vec_lo = 8'hFA;
      TAKE_IRQ: bus.vec_lo = irq_vector(src_id);
      default:  bus.vec_lo = 8'hFE;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed vector bench for int_ctrl (N_IRQ=4, VEC_MODE=1, base E0).
module tb_int_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  int_ctrl_if #(.N_IRQ(4), .IDW(3)) bus ();

  int_ctrl #(
    .N_IRQ(4), .IDW(3), .VEC_MODE(1), .IRQ_VEC_BASE(8'hE0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       rst_n, sync, i_flag, nmi_n;
    logic [3:0] irq_n;
    logic       mask_we;
    logic [3:0] mask_d;
    logic       ack;
    logic       e_rst, e_nmi, e_irq;
    logic [2:0] e_src;
    logic [7:0] e_vec;
    logic [3:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, s, i, n, input logic [3:0] q, input logic mw,
                     input logic [3:0] md, input logic a, input logic er, en, ei,
                     input logic [2:0] es, input logic [7:0] ev, input logic [3:0] ep);
    vec_t v;
    v.rst_n = r; v.sync = s; v.i_flag = i; v.nmi_n = n; v.irq_n = q;
    v.mask_we = mw; v.mask_d = md; v.ack = a;
    v.e_rst = er; v.e_nmi = en; v.e_irq = ei; v.e_src = es; v.e_vec = ev; v.e_pend = ep;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, i, n, input logic [3:0] q, input logic mw,
                       input logic [3:0] md, input logic a);
    rst_n = r; bus.sync = s; bus.i_flag = i; bus.nmi_n = n; bus.irq_n = q;
    bus.mask_we = mw; bus.mask_d = md; bus.ack = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic er, en, ei, input logic [2:0] es,
                           input logic [7:0] ev, input logic [3:0] ep);
    check("rst", idx, 8'(bus.rst), 8'(er));
    check("nmi", idx, 8'(bus.nmi), 8'(en));
    check("irq", idx, 8'(bus.irq), 8'(ei));
    check("src_id", idx, 8'(bus.src_id), 8'(es));
    check("vec_lo", idx, bus.vec_lo, ev);
    check("pending", idx, 8'(bus.pending), 8'(ep));
  endtask

  initial begin
    bit got;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 4'hF, 1'b0);

    // reset, held TAKE_RST, ack to IDLE
    add(0,0,1,1,4'hF,0,4'hF,0, 1,0,0,0,8'hFC,4'h0);
    for (int k = 0; k < 5; k++) add(1,0,1,1,4'hF,0,4'hF,0, 1,0,0,0,8'hFC,4'h0);
    add(1,0,1,1,4'hF,0,4'hF,1, 0,0,0,0,8'hFE,4'h0);
    // NMI held low: one sequence only
    add(1,0,1,0,4'hF,0,4'hF,0, 0,0,0,0,8'hFE,4'h0);
    add(1,1,1,0,4'hF,0,4'hF,0, 0,1,0,0,8'hFA,4'h0);
    add(1,0,1,0,4'hF,0,4'hF,0, 0,1,0,0,8'hFA,4'h0);
    add(1,0,1,0,4'hF,0,4'hF,1, 0,0,0,0,8'hFE,4'h0);
    add(1,1,1,0,4'hF,0,4'hF,0, 0,0,0,0,8'hFE,4'h0);
    add(1,0,1,1,4'hF,0,4'hF,0, 0,0,0,0,8'hFE,4'h0);
    // IRQ sources 2,3; lowest wins; deassert ignored once taken
    add(1,0,0,1,4'h3,0,4'hF,0, 0,0,0,0,8'hFE,4'hC);
    add(1,1,0,1,4'h3,0,4'hF,0, 0,0,1,2,8'hE4,4'hC);
    add(1,0,0,1,4'hF,0,4'hF,0, 0,0,1,2,8'hE4,4'h0);
    add(1,0,0,1,4'hF,0,4'hF,1, 0,0,0,2,8'hFE,4'h0);
    // i_flag blocks, then mask out source 2
    add(1,0,1,1,4'h3,0,4'hF,0, 0,0,0,2,8'hFE,4'hC);
    add(1,1,1,1,4'h3,0,4'hF,0, 0,0,0,2,8'hFE,4'hC);
    add(1,0,1,1,4'h3,1,4'hB,0, 0,0,0,2,8'hFE,4'hC);
    add(1,0,1,1,4'h3,0,4'hF,0, 0,0,0,2,8'hFE,4'h8);
    add(1,1,0,1,4'h3,0,4'hF,0, 0,0,1,3,8'hE6,4'h8);
    add(1,0,0,1,4'h3,0,4'hF,1, 0,0,0,3,8'hFE,4'h8);
    // NMI and IRQ together: NMI first
    add(1,0,0,0,4'h3,0,4'hF,0, 0,0,0,3,8'hFE,4'h8);
    add(1,1,0,0,4'h3,0,4'hF,0, 0,1,0,3,8'hFA,4'h8);
    add(1,0,0,0,4'h3,0,4'hF,1, 0,0,0,3,8'hFE,4'h8);
    add(1,1,0,0,4'h3,0,4'hF,0, 0,0,1,3,8'hE6,4'h8);
    add(1,0,0,0,4'h3,0,4'hF,1, 0,0,0,3,8'hFE,4'h8);
    // NMI edge during TAKE_IRQ held until IDLE
    add(1,0,0,1,4'h3,0,4'hF,0, 0,0,0,3,8'hFE,4'h8);
    add(1,1,0,1,4'h3,0,4'hF,0, 0,0,1,3,8'hE6,4'h8);
    add(1,0,0,0,4'h3,0,4'hF,0, 0,0,1,3,8'hE6,4'h8);
    add(1,0,0,0,4'h3,0,4'hF,1, 0,0,0,3,8'hFE,4'h8);
    add(1,1,0,0,4'h3,0,4'hF,0, 0,1,0,3,8'hFA,4'h8);
    add(1,0,0,0,4'h3,0,4'hF,0, 0,1,0,3,8'hFA,4'h8);
    // new edge while in TAKE_NMI, then reset aborts
    add(1,0,0,1,4'h3,0,4'hF,0, 0,1,0,3,8'hFA,4'h8);
    add(1,0,0,0,4'h3,0,4'hF,0, 0,1,0,3,8'hFA,4'h8);
    add(0,0,0,0,4'h3,0,4'hF,0, 1,0,0,0,8'hFC,4'h0);
    add(1,0,1,1,4'h3,0,4'hF,0, 1,0,0,0,8'hFC,4'hC);
    add(1,0,1,1,4'h3,0,4'hF,1, 0,0,0,0,8'hFE,4'hC);
    add(1,1,1,1,4'h3,0,4'hF,0, 0,0,0,0,8'hFE,4'hC);
    // edge coinciding with ack in TAKE_NMI: set wins
    add(1,0,1,0,4'h3,0,4'hF,0, 0,0,0,0,8'hFE,4'hC);
    add(1,1,1,0,4'h3,0,4'hF,0, 0,1,0,0,8'hFA,4'hC);
    add(1,0,1,1,4'h3,0,4'hF,0, 0,1,0,0,8'hFA,4'hC);
    add(1,0,1,0,4'h3,0,4'hF,1, 0,0,0,0,8'hFE,4'hC);
    add(1,1,1,0,4'h3,0,4'hF,0, 0,1,0,0,8'hFA,4'hC);
    add(1,0,1,0,4'h3,0,4'hF,1, 0,0,0,0,8'hFE,4'hC);
    add(1,1,1,0,4'h3,0,4'hF,0, 0,0,0,0,8'hFE,4'hC);

    step();
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].sync, tbl[i].i_flag, tbl[i].nmi_n, tbl[i].irq_n,
            tbl[i].mask_we, tbl[i].mask_d, tbl[i].ack);
      step();
      check_all(i, tbl[i].e_rst, tbl[i].e_nmi, tbl[i].e_irq, tbl[i].e_src,
                tbl[i].e_vec, tbl[i].e_pend);
    end

    // NMI falling on a sync edge is not taken at that same edge
    drive(1,0,1,1,4'hF,0,4'hF,0); step();
    drive(1,1,1,0,4'hF,0,4'hF,0); step();
    check_all(100, 0,0,0,0,8'hFE,4'h0);
    drive(1,1,1,0,4'hF,0,4'hF,0); step();
    check_all(101, 0,1,0,0,8'hFA,4'h0);
    drive(1,0,1,0,4'hF,0,4'hF,1); step();
    check_all(102, 0,0,0,0,8'hFE,4'h0);

    // irq_n falling with sync high: pending not yet visible, taken later
    drive(1,1,0,0,4'hE,0,4'hF,0); step();
    check_all(103, 0,0,0,0,8'hFE,4'h1);
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      got = bus.irq;
    end
    check("irq_wait", 104, 8'(got), 8'd1);
    check("irq_src0", 105, 8'(bus.src_id), 8'd0);
    check("irq_vec0", 106, bus.vec_lo, 8'hE0);
    drive(1,0,0,0,4'hF,0,4'hF,1); step();
    check_all(107, 0,0,0,0,8'hFE,4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Parametrised successor to the fixed int_seq.
- Arbitrates reset, edge-triggered NMI and N maskable level IRQ sources for the k6502 core.
- Samples pending requests on the opcode-fetch (sync) cycle, holds one selected exception until the microcode acknowledges it, and supplies the vector low byte to the data mux.
- Replaces the hardwired FC/FA/FE selection in the top level and the tied-off nmi_n/irq_n inputs.

Parameters:
N_IRQ, 4, number of IRQ sources (1..8).
IDW, 3, width of src_id; must satisfy 2^IDW >= N_IRQ.
VEC_MODE, 0, 0 = all IRQs use vector 8'hFE; 1 = per-source vector IRQ_VEC_BASE + 2*src_id.
IRQ_VEC_BASE, 8'hE0, base vector low byte for VEC_MODE 1; must be even, and base + 2*(N_IRQ-1) must be <= 8'hF8.

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
sync  in  1  high during the opcode-fetch cycle
i_flag  in  1  CPU status I bit; 1 blocks IRQ
nmi_n  in  1  non-maskable request, falling-edge sensitive
irq_n  in  N_IRQ  maskable requests, active-low level
mask_we  in  1  load enable for the mask register
mask_d  in  N_IRQ  new mask value; bit = 1 enables that source
ack  in  1  microcode has fetched the vector; ends the exception
rst  out  1  reset sequence selected
nmi  out  1  NMI sequence selected
irq  out  1  IRQ sequence selected
src_id  out  IDW  index of the taken IRQ source
vec_lo  out  8  vector low byte
pending  out  N_IRQ  ~irq_n & mask, registered

Behaviour:
- Reset (rst_n low at an edge) sets the following. Reset has priority over every other input.
  - state = TAKE_RST
  - mask = all ones
  - nmi_pend = 0
  - nmi_prev = 1
  - pending = 0
  - src_id = 0
  - Outputs: rst = 1, nmi = 0, irq = 0, vec_lo = 8'hFC.
  - Reset asserted mid-exception aborts that exception and returns to TAKE_RST.
- States: IDLE, TAKE_RST, TAKE_NMI, TAKE_IRQ. Outputs are decoded from the registered state only:
  - rst = (state == TAKE_RST)
  - nmi = (state == TAKE_NMI)
  - irq = (state == TAKE_IRQ)
- vec_lo by state:
  - TAKE_RST: FC
  - TAKE_NMI: FA
  - TAKE_IRQ: FE when VEC_MODE = 0; IRQ_VEC_BASE + {src_id, 1'b0} (8-bit) when VEC_MODE = 1
  - IDLE: FE
- NMI edge detect:
  - nmi_prev <= nmi_n every cycle.
  - nmi_pend is set on any cycle where nmi_prev = 1 and nmi_n = 0.
  - nmi_pend is cleared by ack while in TAKE_NMI. If a new falling edge coincides with that clear, set wins.
  - Holding nmi_n low creates no further requests.
- pending <= ~irq_n & mask every cycle. This gives 1 cycle latency from irq_n.
- mask_we = 1 loads mask <= mask_d; the new mask is effective in pending on the following edge.
- IDLE transitions are evaluated only on edges where sync = 1. Priority:
  1. nmi_pend -> TAKE_NMI
  2. else if (|pending) and i_flag = 0 -> TAKE_IRQ; src_id <= lowest set index of pending
  3. else stay in IDLE
- src_id is frozen for the whole TAKE_IRQ state.
- TAKE_* with ack = 1 -> IDLE on the next edge. ack in IDLE is ignored.
- TAKE_IRQ ignores irq_n deassertion; the exception completes once taken.
- Latency:
  - nmi_n falls at edge t -> nmi_pend is visible after t. The first edge with sync = 1 at t+1 or later enters TAKE_NMI, and nmi = 1 from that edge.
  - irq_n has 1 extra cycle of latency through pending.
- An NMI edge arriving during TAKE_IRQ is held in nmi_pend and taken at the next sync after returning to IDLE.

Test Plan:
- Release reset with sync = 0 for 5 cycles -> rst = 1, vec_lo = FC throughout. Then ack = 1 -> next cycle rst = 0, state IDLE, vec_lo = FE.
- nmi_n 1->0 and held low, then two sync pulses with ack between them -> exactly one nmi pulse sequence with vec_lo = FA. The second sync stays IDLE.
- VEC_MODE = 1, IRQ_VEC_BASE = E0, irq_n = 4'b0011 (sources 2 and 3 active), i_flag = 0, sync -> irq = 1, src_id = 2, vec_lo = E4.
- Same stimulus with i_flag = 1 -> no irq. Separately, mask_d = 4'b1011 with mask_we -> pending = 4'b1000; taken src_id = 3, vec_lo = E6.
- IRQ and NMI edge both pending at the same sync -> TAKE_NMI first. After ack and the next sync -> TAKE_IRQ.
- rst_n low during TAKE_NMI with nmi_pend set -> next cycle rst = 1, nmi = 0, nmi_pend = 0, mask = all ones.
